// File: rtl/conv_out_maxpool.sv
// conv_out_maxpool: 2x2 stride-2 signed max-pool on the conv output stream.
// Even-row horizontal maxima wait in a half-width line buffer for the odd row.
module conv_out_maxpool #(
   parameter int CH_NUM     = 18,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WIDTH  = 512,
   parameter int DIM_BITS   = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DIM_BITS-1:0]          cfg_width,
   input  logic [DIM_BITS-1:0]          cfg_height,
   input  logic                         frame_start,
   input  logic [CH_NUM*DATA_WIDTH-1:0] pool_data_in,
   input  logic                         pool_valid_in,
   output logic [CH_NUM*DATA_WIDTH-1:0] pool_data_out,
   output logic                         pool_valid_out,
   output logic                         frame_done,
   output logic                         busy
);

   localparam int DW       = DATA_WIDTH;
   localparam int PW       = CH_NUM * DATA_WIDTH;
   localparam int LB_DEPTH = MAX_WIDTH / 2;
   localparam int AW       = $clog2(LB_DEPTH);
   localparam logic [DIM_BITS-1:0] ONE = DIM_BITS'(1);

   typedef enum logic [1:0] {
      IDLE,
      EVEN_ROW,
      ODD_ROW
   } state_t;

   state_t              state;
   logic [DIM_BITS-1:0] col;
   logic [DIM_BITS-1:0] row;
   logic [DIM_BITS-1:0] w_r;
   logic [DIM_BITS-1:0] h_even_r;
   logic [PW-1:0]       hold_reg;
   logic [PW-1:0]       lb_rdata;
   logic [PW-1:0]       lb_mem [LB_DEPTH];

   logic                beat;
   logic                last_col;
   logic                last_row;
   logic                lb_we;
   logic                lb_re;
   logic [AW-1:0]       lb_addr;
   logic [PW-1:0]       hmax;
   logic [PW-1:0]       omax;

   function automatic logic [PW-1:0] vmax(
      input logic [PW-1:0] a,
      input logic [PW-1:0] b
   );
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         r[k*DW +: DW] = ($signed(a[k*DW +: DW]) > $signed(b[k*DW +: DW]))
                       ? a[k*DW +: DW] : b[k*DW +: DW];
      end
      return r;
   endfunction

   // Beat qualification, row/column end detection and the max datapath
   always_comb begin
      beat     = pool_valid_in && (state != IDLE) && !frame_start;
      last_col = (col == w_r - ONE);
      last_row = (row == h_even_r - ONE);
      lb_addr  = col[AW:1];
      hmax     = vmax(hold_reg, pool_data_in);
      omax     = vmax(hmax, lb_rdata);
      lb_we    = beat && (state == EVEN_ROW) && col[0];
      lb_re    = beat && (state == ODD_ROW) && !col[0];
   end

   // Line buffer: even-row pair maxima in, synchronous read for the odd row
   always_ff @(posedge clk) begin
      if (lb_we) lb_mem[lb_addr] <= hmax;
      if (lb_re) lb_rdata <= lb_mem[lb_addr];
   end

   // Frame FSM, raster counters and registered pooled output
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         col            <= '0;
         row            <= '0;
         w_r            <= '0;
         h_even_r       <= '0;
         hold_reg       <= '0;
         pool_data_out  <= '0;
         pool_valid_out <= 1'b0;
         frame_done     <= 1'b0;
         busy           <= 1'b0;
      end else begin
         pool_valid_out <= 1'b0;
         frame_done     <= 1'b0;
         if (frame_done) busy <= 1'b0;
         if (frame_start) begin
            w_r      <= cfg_width;
            h_even_r <= cfg_height & ~ONE;
            row      <= '0;
            busy     <= 1'b1;
            state    <= EVEN_ROW;
            if (pool_valid_in) begin
               hold_reg <= pool_data_in;
               col      <= ONE;
            end else begin
               col      <= '0;
            end
         end else if (beat) begin
            if (!col[0]) begin
               hold_reg <= pool_data_in;
            end else if (state == ODD_ROW) begin
               pool_data_out  <= omax;
               pool_valid_out <= 1'b1;
               frame_done     <= last_col && last_row;
            end
            if (last_col) begin
               col <= '0;
               row <= row + ONE;
               unique case (state)
                  EVEN_ROW: state <= ODD_ROW;
                  ODD_ROW:  state <= last_row ? IDLE : EVEN_ROW;
                  default:  state <= IDLE;
               endcase
            end else begin
               col <= col + ONE;
            end
         end
      end
   end

   // Width must be even, non-zero and fit the line buffer
   cfg_width_ok: assert property (@(posedge clk) disable iff (rst)
      frame_start |-> (!cfg_width[0] && cfg_width != '0 &&
                       ({1'b0, cfg_width} <= (DIM_BITS+1)'(MAX_WIDTH))));

endmodule

// File: tb/tb_conv_out_maxpool.sv
// tb_conv_out_maxpool: directed frames against a window-level pooling model.
// Each closing beat queues its expected pooled pixel one cycle later.
module tb_conv_out_maxpool;

   localparam int CH = 18;
   localparam int DW = 8;
   localparam int PW = CH * DW;
   localparam int DB = 10;

   logic          clk;
   logic          rst;
   logic [DB-1:0] cfg_width;
   logic [DB-1:0] cfg_height;
   logic          frame_start;
   logic [PW-1:0] pool_data_in;
   logic          pool_valid_in;
   logic [PW-1:0] pool_data_out;
   logic          pool_valid_out;
   logic          frame_done;
   logic          busy;

   conv_out_maxpool #(
      .CH_NUM(CH), .DATA_WIDTH(DW), .MAX_WIDTH(512), .DIM_BITS(DB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg_width(cfg_width),
      .cfg_height(cfg_height),
      .frame_start(frame_start),
      .pool_data_in(pool_data_in),
      .pool_valid_in(pool_valid_in),
      .pool_data_out(pool_data_out),
      .pool_valid_out(pool_valid_out),
      .frame_done(frame_done),
      .busy(busy)
   );

   typedef struct {
      int            due;
      logic [PW-1:0] d;
      logic          done;
   } exp_t;

   exp_t          exp_q[$];
   logic [PW-1:0] log_q[$];
   logic [PW-1:0] pix [8][8];
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int out_cnt  = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk_v(input string nm, input logic [PW-1:0] act,
                        input logic [PW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic chk_i(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic logic [PW-1:0] window(input int r, input int c);
      logic [PW-1:0] res;
      int m, v;
      res = '0;
      for (int k = 0; k < CH; k++) begin
         m = -1000;
         for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
               v = int'($signed(pix[r-1+dr][c-1+dc][k*DW +: DW]));
               if (v > m) m = v;
            end
         res[k*DW +: DW] = DW'(m);
      end
      return res;
   endfunction

   task automatic drive(input logic v, input logic fs,
                        input logic [PW-1:0] d, output int k);
      @(posedge clk);
      #1;
      pool_valid_in = v;
      frame_start   = fs;
      pool_data_in  = d;
      k = cyc;
   endtask

   task automatic idle(input int n);
      int k;
      repeat (n) drive(1'b0, 1'b0, '0, k);
   endtask

   task automatic run_frame(input int w, input int h, input bit gaps,
                            input int max_beats, input bit fs_with_beat);
      int k, n, he;
      he = h & ~1;
      cfg_width  = DB'(w);
      cfg_height = DB'(h);
      if (!fs_with_beat) drive(1'b0, 1'b1, '0, k);
      n = 0;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            if (n < max_beats) begin
               if (gaps)
                  for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++)
                     drive(1'b0, 1'b0, '0, k);
               drive(1'b1, fs_with_beat && n == 0, pix[r][c], k);
               if (r % 2 == 1 && c % 2 == 1 && r < he)
                  exp_q.push_back('{due: k + 1, d: window(r, c),
                                    done: (r == he - 1 && c == w - 1)});
               n++;
            end
      drive(1'b0, 1'b0, '0, k);
   endtask

   task automatic fill_rand();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            for (int k = 0; k < CH; k++)
               pix[r][c][k*DW +: DW] = DW'($urandom);
   endtask

   // Every cycle: a due entry must appear exactly now, nothing else may
   initial begin
      exp_t e;
      bit   bchk;
      bchk = 0;
      forever begin
         @(negedge clk);
         if (bchk) begin
            bchk = 0;
            chk_i("busy_fall", 32'(busy), 0);
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (pool_valid_out !== 1'b1 || pool_data_out !== e.d ||
                frame_done !== e.done) begin
               failures++;
               $display("FAIL pooled_out@%0d actual v=%b d=%h done=%b required v=1 d=%h done=%b",
                        cyc, pool_valid_out, pool_data_out, frame_done, e.d, e.done);
            end
            if (pool_valid_out === 1'b1) begin
               out_cnt++;
               log_q.push_back(pool_data_out);
            end
            if (e.done) begin
               chk_i("busy_at_done", 32'(busy), 1);
               bchk = 1;
            end
         end else if (pool_valid_out !== 1'b0 || frame_done !== 1'b0) begin
            checks++;
            failures++;
            if (pool_valid_out === 1'b1) out_cnt++;
            $display("FAIL unexpected_out@%0d actual v=%b done=%b required v=0 done=0",
                     cyc, pool_valid_out, frame_done);
         end
      end
   end

   initial begin
      int t1[4];
      logic [PW-1:0] allff;
      int k;
      t1 = '{5, 7, 13, 15};
      allff = {CH{8'hFF}};
      rst = 1;
      cfg_width = '0;
      cfg_height = '0;
      frame_start = 0;
      pool_valid_in = 0;
      pool_data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_v("rst_data", pool_data_out, '0);
      chk_i("rst_valid", 32'(pool_valid_out), 0);
      chk_i("rst_done", 32'(frame_done), 0);
      chk_i("rst_busy", 32'(busy), 0);
      rst = 0;

      // ramp frame
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) pix[r][c] = PW'(r * 4 + c);
      out_cnt = 0;
      log_q.delete();
      run_frame(4, 4, 0, 99, 0);
      idle(4);
      chk_i("t1_count", out_cnt, 4);
      if (log_q.size() == 4)
         for (int i = 0; i < 4; i++)
            chk_i("t1_ch0", 32'(log_q[i][7:0]), t1[i]);
      chk_v("t1_ch_rest", log_q.size() > 0 ? log_q[0] >> 8 : '1, '0);

      // signed window, frame_start together with first beat
      pix[0][0] = {CH{8'h80}};
      pix[0][1] = {CH{8'hFF}};
      pix[1][0] = {CH{8'hFB}};
      pix[1][1] = {CH{8'h80}};
      out_cnt = 0;
      log_q.delete();
      run_frame(2, 2, 0, 99, 1);
      idle(4);
      chk_i("t2_count", out_cnt, 1);
      chk_v("t2_signed", log_q.size() > 0 ? log_q[0] : '0, allff);

      // beats while idle are dropped
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, PW'(i + 50), k);
      idle(3);
      chk_i("idle_drop", out_cnt, 1);

      // random gaps, random data
      fill_rand();
      out_cnt = 0;
      run_frame(8, 6, 1, 99, 0);
      idle(4);
      chk_i("t3_count", out_cnt, 12);

      // odd height: last row ignored
      fill_rand();
      out_cnt = 0;
      run_frame(4, 5, 0, 99, 0);
      idle(4);
      chk_i("t4_count", out_cnt, 4);
      chk_i("t4_busy", 32'(busy), 0);

      // abort at row 1 col 2, restart as 2x2
      fill_rand();
      out_cnt = 0;
      log_q.delete();
      run_frame(4, 4, 0, 6, 0);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) pix[r][c] = '0;
      pix[0][0] = PW'(9);
      pix[0][1] = PW'(3);
      pix[1][0] = PW'(8'hFE);
      pix[1][1] = PW'(4);
      run_frame(2, 2, 0, 99, 1);
      idle(4);
      chk_i("t5_count", out_cnt, 2);
      chk_v("t5_new", log_q.size() > 1 ? log_q[1] : '1, PW'(9));

      // reset mid odd row
      fill_rand();
      run_frame(4, 4, 0, 7, 0);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1;
      chk_v("t6_data", pool_data_out, '0);
      chk_i("t6_valid", 32'(pool_valid_out), 0);
      chk_i("t6_done", 32'(frame_done), 0);
      chk_i("t6_busy", 32'(busy), 0);
      rst = 0;
      out_cnt = 0;
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, PW'(i * 7 + 1), k);
      idle(4);
      chk_i("t6_no_out", out_cnt, 0);
      chk_i("t6_busy_after", 32'(busy), 0);

      idle(3);
      chk_i("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
